// File: rtl/kypd_scan_debounce.sv
// -----------------------------------------------------------------------------
// kypd_scan_debounce
// Parametrised matrix-keypad scanner with frame-based debouncing.
// Drives one active-low column at a time, samples synchronised rows after a
// settle delay, and accepts a single key only after DEBOUNCE_FRAMES identical
// frames. Reports press/release pulses, a held level and multi-key frames.
//
// Optional feature macro: KYPD_REPEAT_EN
//   defined   : auto-repeat of a held key (key_valid + key_repeat pulses)
//   undefined : no repeat logic, key_repeat stays 0
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   row_n        keypad rows, asynchronous, active low
//   col_n        keypad columns, one-hot-low while scanning
//   key_code     last accepted key index (row*N_COLS + col)
//   key_valid    one-cycle pulse: key accepted (or repeated)
//   key_release  one-cycle pulse: held key released
//   key_down     level: a key is currently held
//   key_repeat   qualifies key_valid as an auto-repeat event
//   multi_press  level: last frame saw more than one key
// -----------------------------------------------------------------------------
module kypd_scan_debounce #(
   parameter int unsigned N_ROWS          = 4,
   parameter int unsigned N_COLS          = 4,
   parameter int unsigned COL_CYCLES      = 100000,
   parameter int unsigned SETTLE_CYCLES   = 8,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
`ifdef KYPD_REPEAT_EN
   parameter int unsigned REPEAT_DELAY_FRAMES = 125,
   parameter int unsigned REPEAT_RATE_FRAMES  = 25,
`endif
   localparam int unsigned NK = N_ROWS * N_COLS,
   localparam int unsigned KW = (NK > 1) ? $clog2(NK) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_ROWS-1:0] row_n,
   output logic [N_COLS-1:0] col_n,
   output logic [KW-1:0]     key_code,
   output logic              key_valid,
   output logic              key_release,
   output logic              key_down,
   output logic              key_repeat,
   output logic              multi_press
);

   localparam int unsigned CW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
   localparam int unsigned IW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_FRAMES + 1);
`ifdef KYPD_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                  REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
   localparam int unsigned RW = $clog2(RMAX + 1);
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_DEB = 2'd1,
      HELD      = 2'd2,
      REL_DEB   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Row synchroniser (idle level is high)
   // ---------------------------------------------------------------------------
   logic [N_ROWS-1:0] row_meta;
   logic [N_ROWS-1:0] row_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= '1;
         row_s    <= '1;
      end else begin
         row_meta <= row_n;
         row_s    <= row_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Column sequencer and frame timing
   // ---------------------------------------------------------------------------
   logic          started;
   logic [CW-1:0] col_cnt;
   logic [IW-1:0] col_idx;
   logic          col_last_cyc_c;
   logic          col_wrap_c;
   logic          frame_end_c;
   logic          sample_c;
   logic [IW-1:0] col_idx_nxt_c;

   assign col_last_cyc_c = (col_cnt == CW'(COL_CYCLES - 1));
   assign col_wrap_c     = (col_idx == IW'(N_COLS - 1));
   assign frame_end_c    = started & col_last_cyc_c & col_wrap_c;
   assign sample_c       = started & (col_cnt == CW'(SETTLE_CYCLES));
   assign col_idx_nxt_c  = col_wrap_c ? '0 : col_idx + IW'(1);

   // Keys seen in the current column sample: count saturates at 2 (= "more than one")
   logic [1:0]    col_hits_c;
   logic [KW-1:0] col_key_c;

   always_comb begin
      col_hits_c = 2'd0;
      col_key_c  = '0;
      for (int unsigned r = 0; r < N_ROWS; r++) begin
         if (!row_s[r]) begin
            if (col_hits_c != 2'd2) col_hits_c = col_hits_c + 2'd1;
            col_key_c = KW'(r * N_COLS) + KW'(col_idx);
         end
      end
   end

   // Per-frame accumulation: frm_cnt encodes 0, 1 or 2 (= more than one)
   logic [1:0]    frm_cnt;
   logic [KW-1:0] frm_key;
   logic [2:0]    frm_sum_c;
   logic [1:0]    frm_sat_c;

   assign frm_sum_c = {1'b0, frm_cnt} + {1'b0, col_hits_c};
   assign frm_sat_c = (frm_sum_c >= 3'd2) ? 2'd2 : frm_sum_c[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         col_cnt <= '0;
         col_idx <= '0;
         col_n   <= '1;
         frm_cnt <= 2'd0;
         frm_key <= '0;
      end else begin
         // First cycle out of reset starts column 0
         if (!started) begin
            started <= 1'b1;
            col_cnt <= '0;
            col_idx <= '0;
            col_n   <= ~(N_COLS'(1));
         end else if (col_last_cyc_c) begin
            col_cnt <= '0;
            col_idx <= col_idx_nxt_c;
            col_n   <= ~(N_COLS'(1) << col_idx_nxt_c);
         end else begin
            col_cnt <= col_cnt + CW'(1);
         end

         // Sampling never coincides with frame end since SETTLE < COL_CYCLES-1
         if (frame_end_c) begin
            frm_cnt <= 2'd0;
            frm_key <= '0;
         end else if (sample_c && (col_hits_c != 2'd0)) begin
            frm_cnt <= frm_sat_c;
            frm_key <= col_key_c;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Debounce FSM: advances only at frame end
   // ---------------------------------------------------------------------------
   state_t        state, state_d;
   logic [KW-1:0] cand, cand_d;
   logic [DW-1:0] deb_cnt, deb_cnt_d;
   logic [KW-1:0] key_code_d;
   logic          key_valid_d;
   logic          key_release_d;
   logic          key_down_d;
   logic          key_repeat_d;
   logic          multi_d;
   logic          do_accept_c;
   logic          do_release_c;
   logic          single_c;
   logic          cand_hit_c;
`ifdef KYPD_REPEAT_EN
   logic [RW-1:0] rpt_cnt, rpt_cnt_d;
`endif

   assign single_c   = (frm_cnt == 2'd1);
   assign cand_hit_c = single_c && (frm_key == cand);

   always_comb begin
      state_d       = state;
      cand_d        = cand;
      deb_cnt_d     = deb_cnt;
      key_code_d    = key_code;
      key_down_d    = key_down;
      multi_d       = multi_press;
      key_valid_d   = 1'b0;
      key_release_d = 1'b0;
      key_repeat_d  = 1'b0;
      do_accept_c   = 1'b0;
      do_release_c  = 1'b0;
`ifdef KYPD_REPEAT_EN
      rpt_cnt_d     = rpt_cnt;
`endif

      if (frame_end_c) begin
         multi_d = (frm_cnt == 2'd2);
         case (state)
            IDLE: begin
               if (single_c) begin
                  cand_d = frm_key;
                  if (DEBOUNCE_FRAMES == 1) begin
                     do_accept_c = 1'b1;
                  end else begin
                     deb_cnt_d = DW'(1);
                     state_d   = PRESS_DEB;
                  end
               end
            end
            PRESS_DEB: begin
               if (cand_hit_c) begin
                  if (deb_cnt + DW'(1) == DW'(DEBOUNCE_FRAMES)) do_accept_c = 1'b1;
                  else                                          deb_cnt_d   = deb_cnt + DW'(1);
               end else begin
                  deb_cnt_d = '0;
                  state_d   = IDLE;
               end
            end
            HELD: begin
               if (cand_hit_c) begin
`ifdef KYPD_REPEAT_EN
                  // Countdown to the next repeat; reloaded with the rate after each one
                  if (rpt_cnt <= RW'(1)) begin
                     key_valid_d  = 1'b1;
                     key_repeat_d = 1'b1;
                     rpt_cnt_d    = RW'(REPEAT_RATE_FRAMES);
                  end else begin
                     rpt_cnt_d = rpt_cnt - RW'(1);
                  end
`endif
               end else if (DEBOUNCE_FRAMES == 1) begin
                  do_release_c = 1'b1;
               end else begin
                  deb_cnt_d = DW'(1);
                  state_d   = REL_DEB;
               end
            end
            REL_DEB: begin
               // Returning to HELD keeps the repeat countdown where it was
               if (cand_hit_c) begin
                  deb_cnt_d = '0;
                  state_d   = HELD;
               end else if (deb_cnt + DW'(1) == DW'(DEBOUNCE_FRAMES)) begin
                  do_release_c = 1'b1;
               end else begin
                  deb_cnt_d = deb_cnt + DW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (do_accept_c) begin
         key_code_d  = cand_d;
         key_valid_d = 1'b1;
         key_down_d  = 1'b1;
         deb_cnt_d   = '0;
         state_d     = HELD;
`ifdef KYPD_REPEAT_EN
         rpt_cnt_d   = RW'(REPEAT_DELAY_FRAMES);
`endif
      end

      if (do_release_c) begin
         key_release_d = 1'b1;
         key_down_d    = 1'b0;
         deb_cnt_d     = '0;
         state_d       = IDLE;
`ifdef KYPD_REPEAT_EN
         rpt_cnt_d     = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cand        <= '0;
         deb_cnt     <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         key_down    <= 1'b0;
         key_repeat  <= 1'b0;
         multi_press <= 1'b0;
`ifdef KYPD_REPEAT_EN
         rpt_cnt     <= '0;
`endif
      end else begin
         state       <= state_d;
         cand        <= cand_d;
         deb_cnt     <= deb_cnt_d;
         key_code    <= key_code_d;
         key_valid   <= key_valid_d;
         key_release <= key_release_d;
         key_down    <= key_down_d;
         key_repeat  <= key_repeat_d;
         multi_press <= multi_d;
`ifdef KYPD_REPEAT_EN
         rpt_cnt     <= rpt_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_kypd_scan_debounce.sv
// -----------------------------------------------------------------------------
// tb_kypd_scan_debounce
// Self-checking bench for kypd_scan_debounce (4x4, 16 cycles/column,
// settle 4, debounce 3). A keypad model closes row/column contacts for the
// keys in 'keys'; expected key events are queued per frame and compared by a
// monitor when the DUT pulses key_valid / key_release.
// -----------------------------------------------------------------------------
module tb_kypd_scan_debounce;

   localparam int unsigned NR = 4;
   localparam int unsigned NC = 4;
   localparam logic [15:0] K9 = 16'h0200;
   localparam logic [15:0] K0 = 16'h0001;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NR-1:0] row_n;
   logic [NC-1:0] col_n;
   logic [3:0]    key_code;
   logic          key_valid;
   logic          key_release;
   logic          key_down;
   logic          key_repeat;
   logic          multi_press;

   logic [15:0]   keys      = 16'h0000;
   logic          rows_low  = 1'b0;

   int checks   = 0;
   int failures = 0;
   int frame_no = 0;

   typedef struct {
      logic       valid;
      logic       rel;
      logic       rep;
      logic [3:0] code;
      int         frame;
   } ev_t;

   ev_t exp_q[$];

   always #5 clk = ~clk;

   kypd_scan_debounce #(
      .N_ROWS(4),
      .N_COLS(4),
      .COL_CYCLES(16),
      .SETTLE_CYCLES(4),
`ifdef KYPD_REPEAT_EN
      .REPEAT_DELAY_FRAMES(4),
      .REPEAT_RATE_FRAMES(2),
`endif
      .DEBOUNCE_FRAMES(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .row_n(row_n),
      .col_n(col_n),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_release(key_release),
      .key_down(key_down),
      .key_repeat(key_repeat),
      .multi_press(multi_press)
   );

   // Keypad contact model: key r*NC+c pulls row r low while column c is low
   always_comb begin
      row_n = '1;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (keys[r*NC+c] && !col_n[c]) row_n[r] = 1'b0;
      if (rows_low) row_n = '0;
   end

   // Frame counter and event scoreboard
   initial begin
      logic [NC-1:0] prev_col;
      ev_t e;
      prev_col = '1;
      forever begin
         @(negedge clk);
         if (col_n == 4'b1110 && prev_col != 4'b1110) frame_no++;
         prev_col = col_n;
         if (key_valid === 1'b1 || key_release === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected valid=%b release=%b repeat=%b code=%0d frame=%0d",
                        key_valid, key_release, key_repeat, key_code, frame_no);
            end else begin
               e = exp_q.pop_front();
               if (e.valid !== key_valid || e.rel !== key_release || e.rep !== key_repeat ||
                   e.code !== key_code || e.frame != frame_no) begin
                  failures++;
                  $display("FAIL sb_event got v=%b r=%b rep=%b code=%0d frame=%0d exp v=%b r=%b rep=%b code=%0d frame=%0d",
                           key_valid, key_release, key_repeat, key_code, frame_no,
                           e.valid, e.rel, e.rep, e.code, e.frame);
               end
            end
         end
      end
   end

   // Wait for the next frame start, then present key set k for that frame
   task automatic run_frame(input logic [15:0] k);
      int start;
      bit seen;
      start = frame_no;
      seen  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (frame_no != start) begin
            seen = 1'b1;
            break;
         end
      end
      #1;
      keys = k;
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL frame_timeout got=no_frame_start exp=frame_start");
      end
   endtask

   // Queue an event expected at the start of the next frame
   task automatic push_ev(input logic v, input logic rl, input logic rp, input logic [3:0] code);
      ev_t e;
      e.valid = v;
      e.rel   = rl;
      e.rep   = rp;
      e.code  = code;
      e.frame = frame_no + 1;
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      rows_low = 1'b1;
      keys     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (col_n !== 4'b1111) begin failures++; $display("FAIL rst_col_n got=%b exp=1111", col_n); end
      checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL rst_key_code got=%0d exp=0", key_code); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_key_valid got=%b exp=0", key_valid); end
      checks++; if (key_release !== 1'b0) begin failures++; $display("FAIL rst_key_release got=%b exp=0", key_release); end
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL rst_key_down got=%b exp=0", key_down); end
      checks++; if (key_repeat !== 1'b0) begin failures++; $display("FAIL rst_key_repeat got=%b exp=0", key_repeat); end
      checks++; if (multi_press !== 1'b0) begin failures++; $display("FAIL rst_multi got=%b exp=0", multi_press); end
      rst_n    = 1'b1;
      rows_low = 1'b0;
      @(posedge clk); #1;
      checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL col0_first got=%b exp=1110", col_n); end
      repeat (15) @(posedge clk); #1;
      checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL col0_hold got=%b exp=1110", col_n); end
      @(posedge clk); #1;
      checks++; if (col_n !== 4'b1101) begin failures++; $display("FAIL col1_step got=%b exp=1101", col_n); end
      repeat (48) @(posedge clk); #1;
      checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL col_wrap got=%b exp=1110", col_n); end
   endtask

   task automatic test_press_release;
      run_frame(K9); run_frame(K9); run_frame(K9);
      push_ev(1'b1, 1'b0, 1'b0, 4'd9);
      run_frame('0);
      checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL press_down got=%b exp=1", key_down); end
      checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL press_code got=%0d exp=9", key_code); end
      run_frame('0);
      checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL reldeb_down got=%b exp=1", key_down); end
      run_frame('0);
      push_ev(1'b0, 1'b1, 1'b0, 4'd9);
      run_frame('0);
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL release_down got=%b exp=0", key_down); end
      checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL release_code_hold got=%0d exp=9", key_code); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL press_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? K9 : 16'h0000);
      run_frame('0);
      run_frame('0);
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL bounce_down got=%b exp=0", key_down); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bounce_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_multi;
      run_frame(K9); run_frame(K9); run_frame(K9);
      push_ev(1'b1, 1'b0, 1'b0, 4'd9);
      run_frame(K9);
      checks++; if (multi_press !== 1'b0) begin failures++; $display("FAIL multi_before got=%b exp=0", multi_press); end
      run_frame(K9 | K0);
      run_frame(K9 | K0);
      checks++; if (multi_press !== 1'b1) begin failures++; $display("FAIL multi_f1 got=%b exp=1", multi_press); end
      run_frame(K9);
      checks++; if (multi_press !== 1'b1) begin failures++; $display("FAIL multi_f2 got=%b exp=1", multi_press); end
      checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL multi_down got=%b exp=1", key_down); end
      run_frame(K9);
      checks++; if (multi_press !== 1'b0) begin failures++; $display("FAIL multi_after got=%b exp=0", multi_press); end
      checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL multi_held got=%b exp=1", key_down); end
      run_frame('0); run_frame('0); run_frame('0);
      push_ev(1'b0, 1'b1, 1'b0, 4'd9);
      run_frame('0);
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL multi_rel_down got=%b exp=0", key_down); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL multi_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_reset_mid;
      run_frame(K9); run_frame(K9); run_frame(K9);
      push_ev(1'b1, 1'b0, 1'b0, 4'd9);
      run_frame(K9);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL midrst_down got=%b exp=0", key_down); end
      checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL midrst_code got=%0d exp=0", key_code); end
      checks++; if (col_n !== 4'b1111) begin failures++; $display("FAIL midrst_col got=%b exp=1111", col_n); end
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(K9); run_frame(K9); run_frame(K9);
      push_ev(1'b1, 1'b0, 1'b0, 4'd9);
      run_frame(K9);
      checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL reaccept_down got=%b exp=1", key_down); end
      checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL reaccept_code got=%0d exp=9", key_code); end
      run_frame('0); run_frame('0); run_frame('0);
      push_ev(1'b0, 1'b1, 1'b0, 4'd9);
      run_frame('0);
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL reaccept_rel got=%b exp=0", key_down); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midrst_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
   endtask

`ifdef KYPD_REPEAT_EN
   task automatic test_repeat;
      run_frame(K9); run_frame(K9); run_frame(K9);
      push_ev(1'b1, 1'b0, 1'b0, 4'd9);
      for (int i = 1; i <= 10; i++) begin
         run_frame(K9);
         if (i == 4 || i == 6 || i == 8 || i == 10) push_ev(1'b1, 1'b0, 1'b1, 4'd9);
      end
      run_frame('0);
      checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL repeat_down got=%b exp=1", key_down); end
      run_frame('0); run_frame('0);
      push_ev(1'b0, 1'b1, 1'b0, 4'd9);
      run_frame('0);
      checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL repeat_rel got=%b exp=0", key_down); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL repeat_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
   endtask
`endif

   initial begin
      test_reset();
      test_press_release();
      test_bounce();
      test_multi();
      test_reset_mid();
`ifdef KYPD_REPEAT_EN
      test_repeat();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
